psi_chunk_sched: RTL and testbench

Sequential front-end for the private-set-intersection datapath. Parties' W-bit membership vectors are streamed in C-bit chunks, and the block schedules them chunk-major across N parties. For each chunk it ANDs the N party words into a chunk accumulator, emits the intersected chunk, and keeps a running intersection cardinality. It sits between the party input streams and the downstream result sink, replacing a full-width N×W combinational intersection with a C-bit datapath reused W/C times.

---
 rtl/psi_chunk_sched.sv | 139 +++++++++++++
 tb/tb_psi_chunk_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psi_chunk_sched.sv
`default_nettype none
// ============================================================================
// Module   : psi_chunk_sched
// Brief    : Chunk-major scheduler for a private-set-intersection front-end.
//            ANDs N party words per C-bit chunk, emits each intersected
//            chunk and keeps a running intersection cardinality.
// Revision : 1.0 - initial release
// ============================================================================
module psi_chunk_sched #(
  parameter int W = 1024,
  parameter int C = 64,
  parameter int N = 4,
  localparam int NC = W / C,
  localparam int PW = (N > 1) ? $clog2(N) : 1,
  localparam int IW = (NC > 1) ? $clog2(NC) : 1,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_party,
  input  logic [C-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [C-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic [CW-1:0] card,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] party;
  logic [IW-1:0] chunk;
  logic [C-1:0]  acc;
  logic [C-1:0]  out_q;
  logic [CW-1:0] card_q;
  logic          err_q;
  logic [CW-1:0] pop;

  logic match, last_party, last_chunk;

  assign match      = (in_party == party);
  assign last_party = (party == PW'(N - 1));
  assign last_chunk = (chunk == IW'(NC - 1));

  // State register; reset abandons any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; stalls hold the current state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ACC;
      ACC:     if (in_valid && match && last_party) state_nx = EMIT;
      EMIT:    if (out_ready) state_nx = last_chunk ? DONE : ACC;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Popcount of the chunk currently offered to the sink.
  always_comb begin
    pop = '0;
    for (int i = 0; i < C; i++) pop = pop + CW'(out_q[i]);
  end

  // Datapath: party/chunk counters, accumulator, result and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      party  <= '0;
      chunk  <= '0;
      acc    <= '1;
      out_q  <= '0;
      card_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            party  <= '0;
            chunk  <= '0;
            acc    <= '1;
            card_q <= '0;
            err_q  <= 1'b0;
          end
        end
        ACC: begin
          if (in_valid) begin
            if (match) begin
              acc <= acc & in_data;
              if (last_party) begin
                out_q <= acc & in_data;
                party <= '0;
              end else begin
                party <= party + PW'(1);
              end
            end else begin
              // Out-of-order word: dropped, flagged, accumulation untouched.
              err_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            card_q <= card_q + pop;
            if (!last_chunk) begin
              chunk <= chunk + IW'(1);
              acc   <= '1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs come straight from the registered state.
  assign busy      = (state == ACC) || (state == EMIT);
  assign in_ready  = (state == ACC);
  assign out_valid = (state == EMIT);
  assign out_data  = out_q;
  assign out_idx   = chunk;
  assign out_last  = out_valid && last_chunk;
  assign card      = card_q;
  assign done      = (state == DONE);
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_psi_chunk_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_psi_chunk_sched
// Brief    : Directed self-checking bench for psi_chunk_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psi_chunk_sched;

  localparam int W  = 1024;
  localparam int C  = 64;
  localparam int N  = 4;
  localparam int NC = 16;
  localparam int PW = 2;
  localparam int IW = 4;
  localparam int CW = 11;

  localparam logic [C-1:0] ONES = {C{1'b1}};
  localparam logic [C-1:0] P0   = 64'h00FF_00FF_00FF_00FF;
  localparam logic [C-1:0] P1   = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [C-1:0] PAND = 64'h000F_000F_000F_000F;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_party;
  logic [C-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [C-1:0]  out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic [CW-1:0] card;
  logic          done;
  logic          err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  psi_chunk_sched #(.W(W), .C(C), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_party(in_party), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .card(card), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one party word after 'gap' idle cycles and hold it until accepted.
  task automatic send_word(input int p, input logic [C-1:0] d, input int gap);
    repeat (gap) tick();
    in_valid = 1'b1;
    in_party = PW'(p);
    in_data  = d;
    for (int k = 0; k < 20 && !in_ready; k++) tick();
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_word_timeout: in_ready got %b expected 1 (party %0d)", in_ready, p);
    end
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  function automatic logic [C-1:0] pdata(input int p);
    case (p)
      0:       return P0;
      1:       return P1;
      default: return ONES;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_party = '0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tests++;
    if ({busy, in_ready, out_valid, done, err, card, out_data, out_idx, out_last} !== '0) begin
      fails++;
      $display("FAIL reset_values: got busy=%b in_ready=%b out_valid=%b done=%b err=%b card=%0d expected all 0",
               busy, in_ready, out_valid, done, err, card);
    end
  endtask

  task automatic test_full();
    int c0;
    c0 = cyc;
    do_start();
    for (int ch = 0; ch < NC; ch++) begin
      for (int p = 0; p < N; p++) send_word(p, ONES, 0);
      tests++;
      if ({out_valid, in_ready, out_data, out_idx, out_last} !== {1'b1, 1'b0, ONES, IW'(ch), (ch == NC - 1)}) begin
        fails++;
        $display("FAIL full_chunk%0d: got v=%b rdy=%b data=%h idx=%0d last=%b expected v=1 rdy=0 data=%h idx=%0d last=%b",
                 ch, out_valid, in_ready, out_data, out_idx, out_last, ONES, ch, (ch == NC - 1));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    tests++;
    if (done !== 1'b1 || (cyc - c0) != 81 || card !== CW'(1024)) begin
      fails++;
      $display("FAIL full_done: got done=%b cycle=%0d card=%0d expected done=1 cycle=81 card=1024",
               done, cyc - c0, card);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || card !== CW'(1024)) begin
      fails++;
      $display("FAIL full_idle: got done=%b busy=%b card=%0d expected done=0 busy=0 card=1024", done, busy, card);
    end
  endtask

  task automatic test_partial();
    do_start();
    for (int ch = 0; ch < NC; ch++) begin
      for (int p = 0; p < N; p++) send_word(p, pdata(p), 0);
      tests++;
      if ({out_valid, out_data, out_idx} !== {1'b1, PAND, IW'(ch)}) begin
        fails++;
        $display("FAIL partial_chunk%0d: got v=%b data=%h idx=%0d expected v=1 data=%h idx=%0d",
                 ch, out_valid, out_data, out_idx, PAND, ch);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    tests++;
    if (done !== 1'b1 || card !== CW'(256) || err !== 1'b0) begin
      fails++;
      $display("FAIL partial_done: got done=%b card=%0d err=%b expected done=1 card=256 err=0", done, card, err);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_start();
    for (int ch = 0; ch < NC; ch++) begin
      for (int p = 0; p < N; p++) send_word(p, pdata(p), int'($urandom_range(0, 2)));
      tests++;
      if ({out_valid, out_data, out_idx} !== {1'b1, PAND, IW'(ch)}) begin
        fails++;
        $display("FAIL bp_chunk%0d: got v=%b data=%h idx=%0d expected v=1 data=%h idx=%0d",
                 ch, out_valid, out_data, out_idx, PAND, ch);
      end
      if (ch == 5) begin
        // Offer a word to the block while the sink stalls; it must not be taken.
        in_valid = 1'b1; in_party = '0; in_data = '0;
        for (int s = 0; s < 3; s++) begin
          tick();
          tests++;
          if ({out_valid, in_ready, out_data, out_idx} !== {1'b1, 1'b0, PAND, IW'(5)}) begin
            fails++;
            $display("FAIL bp_stall%0d: got v=%b rdy=%b data=%h idx=%0d expected v=1 rdy=0 data=%h idx=5",
                     s, out_valid, in_ready, out_data, out_idx, PAND);
          end
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    tests++;
    if (done !== 1'b1 || card !== CW'(256) || err !== 1'b0) begin
      fails++;
      $display("FAIL bp_done: got done=%b card=%0d err=%b expected done=1 card=256 err=0", done, card, err);
    end
    tick();
  endtask

  task automatic test_party_error();
    do_start();
    for (int ch = 0; ch < NC; ch++) begin
      if (ch == 0) begin
        send_word(0, P0, 0);
        send_word(2, '0, 0);
        tests++;
        if (err !== 1'b1 || busy !== 1'b1) begin
          fails++;
          $display("FAIL perr_flag: got err=%b busy=%b expected err=1 busy=1", err, busy);
        end
        for (int p = 1; p < N; p++) send_word(p, pdata(p), 0);
      end else begin
        for (int p = 0; p < N; p++) send_word(p, pdata(p), 0);
      end
      tests++;
      if ({out_valid, out_data, out_idx} !== {1'b1, PAND, IW'(ch)}) begin
        fails++;
        $display("FAIL perr_chunk%0d: got v=%b data=%h idx=%0d expected v=1 data=%h idx=%0d",
                 ch, out_valid, out_data, out_idx, PAND, ch);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    tests++;
    if (done !== 1'b1 || err !== 1'b1 || card !== CW'(256)) begin
      fails++;
      $display("FAIL perr_done: got done=%b err=%b card=%0d expected done=1 err=1 card=256", done, err, card);
    end
    repeat (2) tick();
    tests++;
    if (err !== 1'b1 || busy !== 1'b0 || card !== CW'(256)) begin
      fails++;
      $display("FAIL perr_sticky: got err=%b busy=%b card=%0d expected err=1 busy=0 card=256", err, busy, card);
    end
  endtask

  task automatic test_abort();
    do_start();
    tests++;
    if (err !== 1'b0 || busy !== 1'b1 || card !== '0) begin
      fails++;
      $display("FAIL abort_start_clear: got err=%b busy=%b card=%0d expected err=0 busy=1 card=0", err, busy, card);
    end
    for (int ch = 0; ch < 8; ch++) begin
      for (int p = 0; p < N; p++) send_word(p, ONES, 0);
      if (ch < 7) begin
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    end
    tick();
    tests++;
    if ({out_valid, out_idx, card} !== {1'b1, IW'(7), CW'(448)}) begin
      fails++;
      $display("FAIL abort_pre: got v=%b idx=%0d card=%0d expected v=1 idx=7 card=448", out_valid, out_idx, card);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, in_ready, out_valid, done, err, card, out_data, out_idx, out_last} !== '0) begin
      fails++;
      $display("FAIL abort_async: got busy=%b v=%b done=%b card=%0d idx=%0d data=%h expected all 0",
               busy, out_valid, done, card, out_idx, out_data);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_done%0d: got done=%b busy=%b expected 0 0", k, done, busy);
      end
    end
    rst = 1'b0;
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || card !== '0) begin
      fails++;
      $display("FAIL abort_release: got done=%b busy=%b card=%0d expected 0 0 0", done, busy, card);
    end
    test_full();
  endtask

  initial begin
    test_reset();
    test_full();
    test_partial();
    test_backpressure();
    test_party_error();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
